// File: rtl/hangy_autoplayer_if.sv
// Interface between the hangy autoplayer, its controller and the hangy game core.
// The master side starts games and supplies the core's output; the slave side is the autoplayer.
interface hangy_autoplayer_if;
  logic       start;
  logic [6:0] game_out;
  logic [5:0] game_in;
  logic       busy;
  logic       done;
  logic       won;
  logic       exhausted;
  logic [4:0] guess_count;

  modport master (
    output start, game_out,
    input  game_in, busy, done, won, exhausted, guess_count
  );

  modport slave (
    input  start, game_out,
    output game_in, busy, done, won, exhausted, guess_count
  );
endinterface

// File: rtl/hangy_autoplayer.sv
// Scripted self-play for the hangy core: launches a game, then guesses characters in ascending
// order until the core reports win or lose, or the alphabet runs out.
module hangy_autoplayer #(
  parameter int unsigned CHAR_FIRST    = 1,
  parameter int unsigned CHAR_LAST     = 26,
  parameter int unsigned SETTLE_CYCLES = 12,
  parameter int unsigned GEN_CYCLES    = 3
) (
  input logic              clk,
  input logic              reset,
  hangy_autoplayer_if.slave bus
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > GEN_CYCLES) ? SETTLE_CYCLES : GEN_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [4:0]      CharFirst  = 5'(CHAR_FIRST);
  localparam logic [4:0]      CharLast   = 5'(CHAR_LAST);
  localparam logic [CntW-1:0] GenLast    = CntW'(GEN_CYCLES - 1);
  // CHECK is the final idle cycle before the next pulse, so SETTLE covers one cycle less.
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 2);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StGenWait, StPulse, StSettle, StCheck, StDone, StExit
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      char_q;
  logic [4:0]      guess_count_q;
  logic            next_q;
  logic            show_char_q;
  logic            busy_q;
  logic            done_q;
  logic            won_q;
  logic            exhausted_q;

  logic unused_guessed;
  assign unused_guessed = ^bus.game_out[4:0];

  logic [4:0] guess_count_inc;
  assign guess_count_inc = (guess_count_q == 5'd31) ? guess_count_q : guess_count_q + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      char_q        <= CharFirst;
      guess_count_q <= '0;
      next_q        <= 1'b0;
      show_char_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      won_q         <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      next_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            won_q         <= 1'b0;
            exhausted_q   <= 1'b0;
            guess_count_q <= '0;
            char_q        <= CharFirst;
            busy_q        <= 1'b1;
            show_char_q   <= 1'b1;
            next_q        <= 1'b1;
            state_q       <= StLaunch;
          end
        end
        StLaunch: begin
          cnt_q   <= '0;
          state_q <= StGenWait;
        end
        StGenWait: begin
          if (cnt_q == GenLast) begin
            next_q        <= 1'b1;
            guess_count_q <= guess_count_inc;
            state_q       <= StPulse;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPulse: begin
          cnt_q   <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StCheck: begin
          // game_out is sampled only here; win outranks lose, which outranks exhaustion.
          if (bus.game_out[5] || bus.game_out[6] || (char_q == CharLast)) begin
            if (bus.game_out[5]) begin
              won_q <= 1'b1;
            end else if (bus.game_out[6]) begin
              won_q <= 1'b0;
            end else begin
              exhausted_q <= 1'b1;
            end
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            show_char_q <= 1'b0;
            state_q     <= StDone;
          end else begin
            char_q        <= char_q + 5'd1;
            next_q        <= 1'b1;
            guess_count_q <= guess_count_inc;
            state_q       <= StPulse;
          end
        end
        StDone: begin
          if (bus.start) begin
            won_q         <= 1'b0;
            exhausted_q   <= 1'b0;
            guess_count_q <= '0;
            char_q        <= CharFirst;
            busy_q        <= 1'b1;
            show_char_q   <= 1'b1;
            next_q        <= 1'b1;
            cnt_q         <= '0;
            // An exhausted game leaves the core mid-guess, so there is no result to exit from.
            state_q       <= exhausted_q ? StLaunch : StExit;
          end
        end
        StExit: begin
          if (cnt_q == '0) begin
            cnt_q <= CntW'(1);
          end else begin
            next_q  <= 1'b1;
            state_q <= StLaunch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.game_in     = {next_q, show_char_q ? char_q : 5'd0};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.won         = won_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.guess_count = guess_count_q;

endmodule
